// File: rtl/fpdiv.sv
// 11-bit floating-point divider {sign, exp[3:0], frac[5:0]}.
// Restoring mantissa division, one quotient bit per cycle, truncating normalisation.
module fpdiv #(
    parameter int BIAS = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_ready,
    input  logic [10:0] a,
    input  logic [10:0] b,
    output logic [10:0] quotient,
    output logic        done,
    output logic        div_by_zero,
    output logic        overflow,
    output logic        underflow
);

    typedef enum logic [1:0] {StIdle, StDivide, StNorm, StDone} state_e;

    state_e state_q, state_d;

    logic        sign_q;
    logic [3:0]  ea_q, eb_q;
    logic [5:0]  fb_q;
    logic [7:0]  rem_q, quo_q;
    logic [2:0]  cnt_q;
    logic [10:0] res_q, quotient_q;
    logic        dbz_q, ovf_q, unf_q;
    logic        div_by_zero_q, overflow_q, underflow_q, done_q;

    logic [7:0]  divisor;
    logic        rem_ge;
    logic [6:0]  rem_sub, rem_next;

    logic signed [6:0] exp_res;
    logic [5:0]  frac_res;
    logic [10:0] res_d;
    logic        dbz_d, ovf_d, unf_d;

    assign quotient    = quotient_q;
    assign done        = done_q;
    assign div_by_zero = div_by_zero_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (in_ready) state_d = StDivide;
            StDivide: if (cnt_q == 3'd7) state_d = StNorm;
            StNorm:   state_d = StDone;
            StDone:   state_d = StIdle;
        endcase
    end

    // Remainder stays below twice the divisor, so 8 bits suffice and the
    // post-subtract value always fits in 7 bits before the shift.
    always_comb begin
        divisor  = {2'b01, fb_q};
        rem_ge   = (rem_q >= divisor);
        rem_sub  = 7'(rem_q - divisor);
        rem_next = rem_ge ? rem_sub : rem_q[6:0];
    end

    always_comb begin
        exp_res  = $signed({3'b000, ea_q}) - $signed({3'b000, eb_q}) + $signed(7'(BIAS))
                   - (quo_q[7] ? 7'sd0 : 7'sd1);
        frac_res = quo_q[7] ? quo_q[6:1] : quo_q[5:0];
        res_d    = {sign_q, exp_res[3:0], frac_res};
        dbz_d    = 1'b0;
        ovf_d    = 1'b0;
        unf_d    = 1'b0;
        if (eb_q == 4'd0) begin
            res_d = {sign_q, 4'hf, 6'd0};
            dbz_d = 1'b1;
        end else if (ea_q == 4'd0) begin
            res_d = {sign_q, 10'd0};
        end else if (exp_res > 7'sd14) begin
            res_d = {sign_q, 4'hf, 6'd0};
            ovf_d = 1'b1;
        end else if (exp_res < 7'sd1) begin
            res_d = {sign_q, 10'd0};
            unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sign_q        <= 1'b0;
            ea_q          <= '0;
            eb_q          <= '0;
            fb_q          <= '0;
            rem_q         <= '0;
            quo_q         <= '0;
            cnt_q         <= '0;
            res_q         <= '0;
            dbz_q         <= 1'b0;
            ovf_q         <= 1'b0;
            unf_q         <= 1'b0;
            quotient_q    <= '0;
            div_by_zero_q <= 1'b0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (in_ready) begin
                        sign_q <= a[10] ^ b[10];
                        ea_q   <= a[9:6];
                        eb_q   <= b[9:6];
                        fb_q   <= b[5:0];
                        rem_q  <= {2'b01, a[5:0]};
                        quo_q  <= '0;
                        cnt_q  <= '0;
                    end
                end
                StDivide: begin
                    quo_q <= {quo_q[6:0], rem_ge};
                    rem_q <= {rem_next, 1'b0};
                    cnt_q <= cnt_q + 3'd1;
                end
                StNorm: begin
                    res_q <= res_d;
                    dbz_q <= dbz_d;
                    ovf_q <= ovf_d;
                    unf_q <= unf_d;
                end
                StDone: begin
                    quotient_q    <= res_q;
                    div_by_zero_q <= dbz_q;
                    overflow_q    <= ovf_q;
                    underflow_q   <= unf_q;
                    done_q        <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpdiv.sv
// Bench for fpdiv: cycle-level reference model checked every cycle, plus
// directed operations with hand-computed results, latency and busy/reset cases.
module tb_fpdiv;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_ready = 1'b0;
    logic [10:0] a = '0;
    logic [10:0] b = '0;
    logic [10:0] quotient;
    logic        done, div_by_zero, overflow, underflow;

    int n_cmp = 0;
    int n_bad = 0;
    bit armed = 1'b0;

    fpdiv #(.BIAS(7)) dut (
        .clk(clk), .rst_n(rst_n), .in_ready(in_ready), .a(a), .b(b),
        .quotient(quotient), .done(done), .div_by_zero(div_by_zero),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Returns {div_by_zero, overflow, underflow, quotient} from the number format rules.
    function automatic logic [13:0] model_div(input logic [10:0] x, input logic [10:0] y);
        int ex, ey, mx, my, r, e, fr;
        logic s;
        s  = x[10] ^ y[10];
        ex = int'(x[9:6]);
        ey = int'(y[9:6]);
        mx = 64 + int'(x[5:0]);
        my = 64 + int'(y[5:0]);
        if (ey == 0) return {3'b100, s, 4'hf, 6'd0};
        if (ex == 0) return {3'b000, s, 10'd0};
        r = (mx * 128) / my;  // mantissa ratio scaled by 2^7, truncated
        if (r >= 128) begin
            e  = ex - ey + 7;
            fr = (r / 2) % 64;
        end else begin
            e  = ex - ey + 6;
            fr = r % 64;
        end
        if (e > 14) return {3'b010, s, 4'hf, 6'd0};
        if (e < 1)  return {3'b001, s, 10'd0};
        return {3'b000, s, e[3:0], fr[5:0]};
    endfunction

    // Timing model: capture on an idle edge, result published 10 edges later,
    // idle again on the following edge.
    int          busy = 0;
    logic [13:0] pend = '0;
    logic [13:0] exp_out = '0;
    logic        exp_done = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            busy     = 0;
            exp_out  = '0;
            exp_done = 1'b0;
        end else begin
            exp_done = 1'b0;
            if (busy == 0) begin
                if (in_ready) begin
                    pend = model_div(a, b);
                    busy = 10;
                end
            end else begin
                busy--;
                if (busy == 0) begin
                    exp_out  = pend;
                    exp_done = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            check("model done", 32'(done), 32'(exp_done));
            check("model quotient", 32'(quotient), 32'(exp_out[10:0]));
            check("model flags", 32'({div_by_zero, overflow, underflow}), 32'(exp_out[13:11]));
        end
    end

    task automatic run_op(input logic [10:0] x, input logic [10:0] y, input logic [10:0] q_exp,
                          input logic [2:0] f_exp, input string nm, input bit disturb);
        int n;
        @(posedge clk); #1;
        a = x; b = y; in_ready = 1'b1;
        @(posedge clk); #1;  // capture edge
        in_ready = 1'b0;
        n = 0;
        while (!done && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (disturb && n == 3) begin
                a = 11'b0_0111_000000; b = 11'b0_0111_100000; in_ready = 1'b1;
            end
            if (n == 4) in_ready = 1'b0;
        end
        check({nm, " latency"}, 32'(n), 32'd10);
        check({nm, " quotient"}, 32'(quotient), 32'(q_exp));
        check({nm, " flags"}, 32'({div_by_zero, overflow, underflow}), 32'(f_exp));
    endtask

    initial begin
        int t, t1, t2, seen;
        @(posedge clk); #1;
        armed = 1'b1;
        @(posedge clk); #1;
        check("reset quotient", 32'(quotient), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset flags", 32'({div_by_zero, overflow, underflow}), 32'd0);
        rst_n = 1'b1;

        run_op(11'b0_0111_000000, 11'b0_0111_000000, 11'b0_0111_000000, 3'b000, "1/1", 1'b0);
        run_op(11'b0_1001_100000, 11'b0_1000_000000, 11'b0_1000_100000, 3'b000, "6/2", 1'b0);
        run_op(11'b1_1000_100000, 11'b0_0111_100000, 11'b1_1000_000000, 3'b000, "-3/1.5", 1'b0);
        run_op(11'b0_0111_000000, 11'b0_0111_100000, 11'b0_0110_010101, 3'b000, "1/1.5", 1'b0);
        run_op(11'b0_1000_000000, 11'b0_0000_000000, 11'b0_1111_000000, 3'b100, "dbz", 1'b0);
        run_op(11'b0_1110_000000, 11'b0_0001_000000, 11'b0_1111_000000, 3'b010, "ovf", 1'b0);
        run_op(11'b0_0001_000000, 11'b0_1110_000000, 11'b0_0000_000000, 3'b001, "unf", 1'b0);
        run_op(11'b0_1001_100000, 11'b0_1000_000000, 11'b0_1000_100000, 3'b000, "busy", 1'b1);

        // Back-to-back with in_ready held high.
        @(posedge clk); #1;
        a = 11'b0_1001_100000; b = 11'b0_1000_000000; in_ready = 1'b1;
        t = 0; t1 = -1; t2 = -1;
        while (t2 < 0 && t < 40) begin
            @(posedge clk); #1;
            t++;
            if (done) begin
                if (t1 < 0) t1 = t;
                else t2 = t;
            end
        end
        in_ready = 1'b0;
        check("b2b spacing", 32'(t2 - t1), 32'd11);
        check("b2b quotient", 32'(quotient), 32'(11'b0_1000_100000));
        repeat (12) @(posedge clk);

        // Reset in the middle of DIVIDE.
        @(posedge clk); #1;
        a = 11'b0_0111_000000; b = 11'b0_0111_000000; in_ready = 1'b1;
        @(posedge clk); #1;
        in_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("abort quotient", 32'(quotient), 32'd0);
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done) seen++;
        end
        check("abort no done", 32'(seen), 32'd0);
        run_op(11'b1_1000_100000, 11'b0_0111_100000, 11'b1_1000_000000, 3'b000, "post-reset", 1'b0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
